// File: rtl/vga_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing and coordinate width.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_CLK_DIV   = 4;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-enable divider: one-clk p_tick every CLK_DIV board clocks.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = vga_pkg::VGA_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Next divider value: count up, wrap after the last phase.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: x/y counters, sync/blank decode and line/frame pulses.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic               tick;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               line_tick_q, line_tick_d;
  logic               frame_tick_q, frame_tick_d;
  logic               x_last;
  logic               y_last;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  // Raster position advance, one pixel per p_tick.
  always_comb begin
    x_last = (32'(x_q) == H_TOTAL - 1);
    y_last = (32'(y_q) == V_TOTAL - 1);
    x_d    = x_q;
    y_d    = y_q;
    if (tick) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d = '0;
        end else begin
          y_d = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Sync/blank decode from the next position so they stay aligned with x/y;
  // line/frame pulses are single-clk regardless of the divider.
  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    if (tick) begin
      hsync_d      = !((32'(x_d) >= HS_START) && (32'(x_d) <= HS_END));
      vsync_d      = !((32'(y_d) >= VS_START) && (32'(y_d) <= VS_END));
      video_on_d   = (32'(x_d) < H_DISPLAY) && (32'(y_d) < V_DISPLAY);
      line_tick_d  = x_last;
      frame_tick_d = x_last && y_last;
    end
  end

  // Position and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign p_tick     = tick;
  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480 @ 60 Hz VGA raster timing for the pong display. Sits directly upstream of every glyph and sprite renderer: its `x`/`y` outputs drive their pixel-coordinate inputs, and its sync outputs go to the VGA connector. A pixel-enable divider is built in, so the block runs on the single 100 MHz board clock.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, board clocks per pixel (must be 2 or more)
- clk  in  1  board clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- p_tick  out  1  pixel enable, high for one clk every CLK_DIV clks
- x  out  10  current pixel column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while x < H_DISPLAY and y < V_DISPLAY
- line_tick  out  1  one-clk pulse at the start of each line
- frame_tick  out  1  one-clk pulse at the start of each frame

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - p_tick = (div_cnt == CLK_DIV-1). This is combinational from the register.
- On each clk edge where p_tick is high:
  - x increments.
  - At x == H_TOTAL-1, x wraps to 0 and y increments.
  - At y == V_TOTAL-1 with x == H_TOTAL-1, y also wraps to 0.
- All sync and status outputs are registered. They are computed from the next x/y values, so they change on the same edge as x/y and always match the current x/y:
  - hsync = 0 iff next_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656, 751].
  - vsync = 0 iff next_y in [490, 491].
  - video_on = (next_x < 640) && (next_y < 480).
  - line_tick = 1 for the one clk after the edge where x wrapped to 0.
  - frame_tick = 1 for the one clk after the edge where both x and y wrapped to 0.
- Counters are unsigned and 10 bits wide. Comparisons use the widths of the parameter constants. No other wrap conditions exist.

## Timing
- Reset values, applied asynchronously:
  - div_cnt=0, x=0, y=0.
  - hsync=1, vsync=1.
  - video_on=0, line_tick=0, frame_tick=0.
- Release: the first p_tick occurs CLK_DIV clks after reset deasserts. On that edge x becomes 1 and video_on becomes 1. Pixel (0,0) of the first frame after reset is blanked; this is intended.
- Latency: the outputs of x/y/sync/video_on are mutually aligned with zero offset. Downstream renderers are combinational, so their pixel data is aligned with video_on.
- Reset asserted mid-frame: all outputs return to reset values at once. No partial sync pulse is held.
- Between p_ticks, every output is stable for CLK_DIV clks.
- line_tick and frame_tick last exactly one clk each, not CLK_DIV clks.
- When a frame wraps, line_tick and frame_tick are high in the same cycle.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks.

## Structure
- Shared package `vga_pkg`:
  - default timing constants (the 640x480 values above);
  - H_TOTAL and V_TOTAL;
  - the pixel coordinate width (10).
- Renderers and game logic import `vga_pkg` for screen bounds.
- One sub-module, `pixel_tick_gen`:
  - contains the CLK_DIV counter;
  - is reset by the same asynchronous reset;
  - outputs p_tick.
- Everything else (counters, decode, output registers) stays in `vga_timing`.

## Test plan
- Reset, then release.
  - p_tick first high at clk 4 after release.
  - x=1, y=0, video_on=1 after that edge.
  - hsync=1, vsync=1.
- Run one full line.
  - hsync low for exactly 96*4=384 clks.
  - The falling edge comes on the edge where x becomes 656; the rising edge on the edge where x becomes 752.
  - video_on drops on the edge where x becomes 640.
- Run one full frame.
  - vsync low exactly while y is 490 or 491, i.e. 2*800*4 clks.
  - frame_tick pulses once, 1 clk wide, after y:524→0 and x:799→0.
  - line_tick pulses in that same cycle.
- Measure two frames back to back.
  - The interval between frame_tick pulses is 1,680,000 clks.
  - There are 525 line_ticks per frame.
  - x never exceeds 799 and y never exceeds 524.
- Assert reset mid-frame at x=300, y=200, during a p_tick cycle.
  - All outputs take reset values within the same clk, without waiting for an edge.
  - After release, the timing matches the first scenario.
- Instantiate with CLK_DIV=2 and a small raster (H 8/2/2/2, V 4/1/1/1).
  - hsync/vsync windows follow the parameter formulas.
  - The frame period is 14*7*2=196 clks.
